// File: rtl/drive_program_sequencer.sv
// drive_program_sequencer
//   Records a short program of drive commands (direction + torque level) from
//   button presses and replays it, holding each command for STEP_CYCLES clocks,
//   either once or repeatedly.
//
// Ports
//   CLOCK50     system clock (rising edge)
//   reset       asynchronous active-high reset; clears the program count
//   save        append {cmd_dir, cmd_torque} (rising edge of the level button)
//   execute     start a run from IDLE, or abort a run in progress
//   delete      drop the last stored command
//   loop_mode   1 = wrap to step 0 after the last step, 0 = single pass
//   cmd_dir     00 fwd, 01 rev, 10 left, 11 right
//   cmd_torque  torque level of the command being saved
//   dir_out     direction of the active step (0 when idle)
//   dir_valid   high while a step is being driven
//   left_bar    left torque thermometer
//   right_bar   right torque thermometer
//   count       number of stored commands
//   step_idx    index of the executing step
//   busy        high while running
//   full/empty  count == DEPTH / count == 0
//   done        one-cycle pulse when a single-pass run completes
module drive_program_sequencer #(
  parameter int DEPTH       = 8,
  parameter int TORQUE_W    = 2,
  parameter int LED_W       = 9,
  parameter int STEP_CYCLES = 50,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                CLOCK50,
  input  logic                reset,
  input  logic                save,
  input  logic                execute,
  input  logic                delete,
  input  logic                loop_mode,
  input  logic [1:0]          cmd_dir,
  input  logic [TORQUE_W-1:0] cmd_torque,
  output logic [1:0]          dir_out,
  output logic                dir_valid,
  output logic [LED_W-1:0]    left_bar,
  output logic [LED_W-1:0]    right_bar,
  output logic [CW-1:0]       count,
  output logic [IW-1:0]       step_idx,
  output logic                busy,
  output logic                full,
  output logic                empty,
  output logic                done
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int EW = 2 + TORQUE_W;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [IW-1:0] step_reg, step_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          done_next;
  logic          mem_we;

  // Bit order {delete, execute, save} in both button registers.
  logic [2:0] btn_reg, btn_prev_reg;
  logic       save_edge, exec_edge, del_edge;

  logic [EW-1:0]       mem [DEPTH];
  logic [EW-1:0]       rd_entry;
  logic [1:0]          rd_dir;
  logic [TORQUE_W-1:0] rd_torque;
  int                  fill_n;
  logic [LED_W-1:0]    fill_bar;
  logic                run_next;

  assign save_edge = btn_reg[0] & ~btn_prev_reg[0];
  assign exec_edge = btn_reg[1] & ~btn_prev_reg[1];
  assign del_edge  = btn_reg[2] & ~btn_prev_reg[2];

  assign count    = count_reg;
  assign step_idx = step_reg;
  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    step_next  = step_reg;
    timer_next = timer_reg;
    done_next  = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Execute wins over a coincident save/delete; save+delete together cancel.
        if (exec_edge && count_reg != '0) begin
          state_next = RUN;
          step_next  = '0;
          timer_next = '0;
        end else if (save_edge && !del_edge && count_reg < CW'(DEPTH)) begin
          mem_we     = 1'b1;
          count_next = count_reg + CW'(1);
        end else if (del_edge && !save_edge && count_reg != '0) begin
          count_next = count_reg - CW'(1);
        end
      end
      RUN: begin
        if (exec_edge) begin
          state_next = IDLE;
          step_next  = '0;
          timer_next = '0;
        end else if (timer_reg == TW'(STEP_CYCLES - 1)) begin
          timer_next = '0;
          if (CW'(step_reg) < count_reg - CW'(1)) begin
            step_next = step_reg + IW'(1);
          end else if (loop_mode) begin
            step_next = '0;
          end else begin
            state_next = IDLE;
            step_next  = '0;
            done_next  = 1'b1;
          end
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Program store: no reset so it maps onto RAM; count alone defines validity.
  always_ff @(posedge CLOCK50) begin
    if (mem_we) mem[count_reg[IW-1:0]] <= {cmd_dir, cmd_torque};
  end

  // Outputs are looked up for the step about to be driven, so they are
  // correct on the very first RUN cycle and switch exactly on step boundaries.
  assign run_next  = (state_next == RUN);
  assign rd_entry  = mem[step_next];
  assign rd_dir    = rd_entry[EW-1 -: 2];
  assign rd_torque = rd_entry[TORQUE_W-1:0];
  assign fill_n    = ((int'(rd_torque) + 1) * LED_W) >> TORQUE_W;

  for (genvar gi = 0; gi < LED_W; gi++) begin : g_fill
    assign fill_bar[gi] = (fill_n > gi);
  end

  always_ff @(posedge CLOCK50 or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      step_reg     <= '0;
      timer_reg    <= '0;
      btn_reg      <= '0;
      btn_prev_reg <= '0;
      dir_out      <= '0;
      dir_valid    <= 1'b0;
      left_bar     <= '0;
      right_bar    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      btn_reg      <= {delete, execute, save};
      btn_prev_reg <= btn_reg;
      state_reg    <= state_next;
      count_reg    <= count_next;
      step_reg     <= step_next;
      timer_reg    <= timer_next;
      dir_out      <= run_next ? rd_dir : 2'b00;
      dir_valid    <= run_next;
      busy         <= run_next;
      done         <= done_next;
      // A left turn drives only the right wheel, a right turn only the left.
      left_bar     <= (run_next && rd_dir != DIR_LEFT)  ? fill_bar : '0;
      right_bar    <= (run_next && rd_dir != DIR_RIGHT) ? fill_bar : '0;
    end
  end

endmodule

// File: tb/tb_drive_program_sequencer.sv
module tb_drive_program_sequencer;
  localparam int S = 50;

  logic clk = 1'b0;
  logic reset, save, execute, del, loop_mode;
  logic [1:0] cmd_dir;
  logic [1:0] cmd_torque;
  logic [1:0] dir_out;
  logic dir_valid, busy, full, empty, done;
  logic [8:0] left_bar, right_bar;
  logic [3:0] count;
  logic [2:0] step_idx;

  // Second instance: STEP_CYCLES=1, TORQUE_W=3, LED_W=8, DEPTH=4.
  logic s_save, s_execute, s_del, s_loop;
  logic [1:0] s_cmd_dir, s_dir_out;
  logic [2:0] s_cmd_torque, s_count;
  logic [7:0] s_left, s_right;
  logic [1:0] s_step;
  logic s_dir_valid, s_busy, s_full, s_empty, s_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] prog[$];
  int fill_tab[4];

  always #5 clk = ~clk;

  drive_program_sequencer dut (
    .CLOCK50(clk), .reset(reset), .save(save), .execute(execute), .delete(del),
    .loop_mode(loop_mode), .cmd_dir(cmd_dir), .cmd_torque(cmd_torque),
    .dir_out(dir_out), .dir_valid(dir_valid), .left_bar(left_bar), .right_bar(right_bar),
    .count(count), .step_idx(step_idx), .busy(busy), .full(full), .empty(empty), .done(done)
  );

  drive_program_sequencer #(.DEPTH(4), .TORQUE_W(3), .LED_W(8), .STEP_CYCLES(1)) dut_s (
    .CLOCK50(clk), .reset(reset), .save(s_save), .execute(s_execute), .delete(s_del),
    .loop_mode(s_loop), .cmd_dir(s_cmd_dir), .cmd_torque(s_cmd_torque),
    .dir_out(s_dir_out), .dir_valid(s_dir_valid), .left_bar(s_left), .right_bar(s_right),
    .count(s_count), .step_idx(s_step), .busy(s_busy), .full(s_full), .empty(s_empty), .done(s_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {dir_out, dir_valid, left_bar, right_bar, step_idx, busy, done}
  function automatic logic [26:0] obs_vec();
    return {dir_out, dir_valid, left_bar, right_bar, step_idx, busy, done};
  endfunction

  function automatic logic [26:0] idle_vec(input logic d);
    return {2'b00, 1'b0, 9'd0, 9'd0, 3'd0, 1'b0, d};
  endfunction

  function automatic logic [26:0] exp_run(input int idx);
    logic [3:0] e;
    logic [1:0] d;
    logic [8:0] fill, l, r;
    e = prog[idx];
    d = e[3:2];
    fill = 9'((1 << fill_tab[e[1:0]]) - 1);
    l = (d == 2'b10) ? 9'd0 : fill;
    r = (d == 2'b11) ? 9'd0 : fill;
    return {d, 1'b1, l, r, 3'(idx), 1'b1, 1'b0};
  endfunction

  task automatic check_count(input string tag);
    check(tag, {count, full, empty},
          {4'(prog.size()), prog.size() == 8, prog.size() == 0});
  endtask

  // Called at a negedge; returns at a negedge after the action has landed.
  task automatic press(input bit s, input bit d, input int hold);
    save = s;
    del = d;
    repeat (hold) @(negedge clk);
    save = 1'b0;
    del = 1'b0;
    repeat (2) @(negedge clk);
    if (s && !d && prog.size() < 8) prog.push_back({cmd_dir, cmd_torque});
    else if (d && !s && prog.size() > 0) void'(prog.pop_back());
  endtask

  task automatic save_cmd(input logic [1:0] d, input logic [1:0] t, input int hold);
    cmd_dir = d;
    cmd_torque = t;
    press(1'b1, 1'b0, hold);
    check_count($sformatf("save d=%0d t=%0d", d, t));
  endtask

  task automatic start_exec();
    execute = 1'b1;
    @(negedge clk);
    execute = 1'b0;
    @(negedge clk);
  endtask

  // Cycle k=0 is the first RUN cycle. abort_k<0 means no abort.
  task automatic run_check(input bit lp, input int abort_k, input int max_k);
    int n;
    logic [26:0] e;
    n = prog.size();
    loop_mode = lp;
    start_exec();
    for (int k = 0; k < max_k; k++) begin
      if (abort_k >= 0 && k > abort_k + 1) e = idle_vec(1'b0);
      else if (!lp && k >= n * S) e = idle_vec(k == n * S);
      else e = exp_run((k / S) % n);
      check($sformatf("run lp=%0d k=%0d", lp, k), obs_vec(), e);
      execute = (k == abort_k);
      @(negedge clk);
    end
    execute = 1'b0;
  endtask

  initial begin
    fill_tab = '{2, 4, 6, 9};
    reset = 1'b1;
    {save, execute, del, loop_mode} = '0;
    cmd_dir = '0;
    cmd_torque = '0;
    {s_save, s_execute, s_del, s_loop} = '0;
    s_cmd_dir = '0;
    s_cmd_torque = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", obs_vec(), idle_vec(1'b0));
    check_count("reset count");
    reset = 1'b0;
    @(negedge clk);

    // Directed program; the first save is held 20 cycles.
    save_cmd(2'b00, 2'd0, 20);
    save_cmd(2'b00, 2'd1, 1);
    save_cmd(2'b00, 2'd2, 3);
    save_cmd(2'b00, 2'd3, 1);
    save_cmd(2'b10, 2'd2, 2);
    run_check(1'b0, -1, 5 * S + 3);
    check_count("count after single pass");
    run_check(1'b1, 5 * S + 60, 5 * S + 70);
    check_count("count after abort");

    // Boundaries.
    press(1'b0, 1'b1, 1);
    press(1'b0, 1'b1, 1);
    check_count("delete to 3");
    press(1'b1, 1'b1, 2);
    check_count("save+delete no-op");
    for (int i = 0; i < 9; i++) press(1'b0, 1'b1, 1);
    check_count("9 deletes");
    start_exec();
    repeat (3) begin
      check("execute on empty", obs_vec(), idle_vec(1'b0));
      @(negedge clk);
    end
    for (int i = 0; i < 9; i++) save_cmd(2'(i), 2'(i + 1), 1);

    // Random edit sequences, each followed by a single pass and an aborted loop.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) begin
        int op;
        op = $urandom_range(0, 9);
        cmd_dir = 2'($urandom);
        cmd_torque = 2'($urandom);
        press(op <= 5 || op == 9, op >= 6, $urandom_range(1, 4));
        check_count($sformatf("rand op=%0d", op));
      end
      if (prog.size() > 0) begin
        run_check(1'b0, -1, prog.size() * S + 3);
        begin
          int ak;
          ak = $urandom_range(0, prog.size() * S * 2);
          run_check(1'b1, ak, ak + 5);
        end
      end
    end

    // Reset during step 2 of a single-pass run.
    while (prog.size() < 3) save_cmd(2'b01, 2'd3, 1);
    run_check(1'b0, -1, 2 * S + 10);
    #2 reset = 1'b1;
    #1;
    check("async reset outputs", obs_vec(), idle_vec(1'b0));
    prog.delete();
    check_count("async reset count");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    save_cmd(2'b11, 2'd1, 1);
    save_cmd(2'b01, 2'd0, 1);
    run_check(1'b0, -1, 2 * S + 3);

    // Small configuration: one cycle per step, 8-bit bars from 3-bit torque.
    s_cmd_dir = 2'b00;
    s_cmd_torque = 3'd7;
    s_save = 1'b1;
    @(negedge clk);
    s_save = 1'b0;
    repeat (2) @(negedge clk);
    s_cmd_dir = 2'b01;
    s_cmd_torque = 3'd0;
    s_save = 1'b1;
    @(negedge clk);
    s_save = 1'b0;
    repeat (2) @(negedge clk);
    check("small count", {s_count, s_full, s_empty}, {3'd2, 1'b0, 1'b0});
    s_execute = 1'b1;
    @(negedge clk);
    s_execute = 1'b0;
    @(negedge clk);
    check("small step0", {s_dir_out, s_left, s_right, s_step, s_busy, s_done},
          {2'b00, 8'hFF, 8'hFF, 2'd0, 1'b1, 1'b0});
    @(negedge clk);
    check("small step1", {s_dir_out, s_left, s_right, s_step, s_busy, s_done},
          {2'b01, 8'h01, 8'h01, 2'd1, 1'b1, 1'b0});
    @(negedge clk);
    check("small done", {s_dir_out, s_left, s_right, s_step, s_busy, s_done},
          {2'b00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1});
    @(negedge clk);
    check("small after done", {s_busy, s_done, s_count}, {1'b0, 1'b0, 3'd2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
